// File: rtl/mux_arb_pkg.sv
// Shared constants for the registered N:1 selector/arbiter.
package mux_arb_pkg;

  // Selection mode driven on the mux_arb_reg mode input.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Per-channel grant counter geometry (MUX_ARB_GRANT_CNT_EN builds only).
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps
// modulo NUM_IN; the first requesting channel wins.
module rr_arbiter #(
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  // Rotating priority search; both loops are constant-bounded so every index
  // is a static select after unrolling.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!any_gnt && req[i] && (i == ((32'(ptr) + k) % NUM_IN))) begin
          any_gnt = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// Parametrised NUM_IN:1, WIDTH-bit registered selector with valid/ready
// handshakes. Fixed-select or round-robin arbitration feeds a one-entry
// output register stage.
// Optional: define MUX_ARB_GRANT_CNT_EN to add the grant_cnt output with one
// saturating 16-bit transfer counter per channel.
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter  int unsigned WIDTH  = 64,
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_IN*CNT_W-1:0] grant_cnt
`endif
);

  logic              mode_rr;
  logic              load;
  logic              sel_ok;
  logic [NUM_IN-1:0] fix_gnt;
  logic [NUM_IN-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;
  logic [SEL_W-1:0]  rr_ptr;
  logic              xfer;
  logic [SEL_W-1:0]  xfer_idx;
  logic [WIDTH-1:0]  xfer_data;

  assign mode_rr = (mode == MODE_RR);
  assign load    = !out_valid || out_ready;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  // Fixed-mode one-hot decode of sel; an out-of-range sel selects nothing.
  always_comb begin
    sel_ok  = (32'(sel) < NUM_IN);
    fix_gnt = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      fix_gnt[i] = sel_ok && (32'(sel) == i);
    end
  end

  // Per-channel ready: only the chosen channel, only when the output stage
  // can load, and never while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (reset_n && load) begin
      if (mode_rr) begin
        in_ready = rr_any ? rr_gnt : '0;
      end else begin
        in_ready = fix_gnt;
      end
    end
  end

  // Transfer detection and selected-channel data mux.
  always_comb begin
    xfer      = |(in_valid & in_ready);
    xfer_idx  = mode_rr ? rr_idx : sel;
    xfer_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(xfer_idx) == i) begin
        xfer_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-entry output stage: loads on a transfer, empties when drained with
  // nothing new, holds everything under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= xfer_data;
        out_src  <= xfer_idx;
      end
    end
  end

  // Round-robin pointer: moves to the winner only on an RR-mode transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= SEL_W'(NUM_IN - 1);
    end else if (mode_rr && xfer) begin
      rr_ptr <= rr_idx;
    end
  end

`ifdef MUX_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_IN];

  // Saturating per-channel transfer counters, counted in either mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (in_valid[i] && in_ready[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pack counters onto the flat output port.
  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
  end
`endif

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised N-input, WIDTH-bit registered selector with valid/ready handshakes; successor to the datapath 2:1 mux.
- Selects one of NUM_IN input channels, either by an explicit select (fixed mode) or by round-robin over valid inputs (RR mode).
- Registers the result in a one-entry output stage.
- Sits between multiple producers (e.g. writeback/forwarding sources, memory response queues) and a single consumer.

Parameters:
- WIDTH, 64, data width per channel.
- NUM_IN, 4, number of input channels, >=2.
- SEL_W, $clog2(NUM_IN), width of the select and source-index fields; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output stage holds data.
- out_ready  input  1  consumer accepts.

Clock and reset (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- load = !out_valid || out_ready. A transfer occurs on an input channel when in_valid[i] && in_ready[i]. At most one channel is granted per cycle.
- Fixed mode (mode=0):
  - in_ready[sel] = load; all other in_ready bits = 0.
  - If sel >= NUM_IN, all in_ready = 0 and no grant.
- RR mode (mode=1):
  - Rotating priority search starts at rr_ptr+1 and wraps modulo NUM_IN; the first i with in_valid[i] is granted.
  - in_ready = load ? onehot(grant) : 0.
  - in_ready may depend combinationally on in_valid. in_valid must never depend on in_ready.
- rr_ptr:
  - Reset value NUM_IN-1, so channel 0 has first priority.
  - Updates to the granted index only on an RR-mode transfer.
  - Held in fixed mode and while no grant occurs.
- Latency: 1 cycle. A transfer in cycle t gives out_valid=1 in cycle t+1, with out_data = in_data[grant] and out_src = grant.
- Output stage:
  - If load and no grant: out_valid clears to 0; out_data and out_src hold their last values.
  - If out_valid && !out_ready: out_data, out_src and out_valid hold, and in_ready = 0.
  - If out_ready and a new grant occur in the same cycle: the output is replaced with no bubble, giving one transfer per cycle sustained.
- Mode or sel changes take effect in the same cycle for arbitration only; they never alter a held output.
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1.
- Reset asserted mid-transfer drops the held output. No transfer is reported in the reset cycle.
- in_ready is 0 while reset_n=0.

Optional Feature:
- Macro: MUX_ARB_GRANT_CNT_EN.
- With it defined:
  - Extra output port grant_cnt, width NUM_IN*16; channel i occupies [i*16 +: 16].
  - Each counter increments by 1 on every transfer from its channel, in either mode.
  - Counters saturate at 16'hFFFF and reset to 0.
- Without it: the port and counters are absent, with no other behavioural difference.

Decomposition:
- Package mux_arb_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - CNT_W=16 and CNT_MAX=16'hFFFF.
- One sub-module, rr_arbiter, is combinational:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index and any-grant flag.
  - Parameterised by NUM_IN.
- The output register stage and rr_ptr stay in mux_arb_reg.

Test Plan:
- Reset: reset_n=0 asynchronously while out_valid=1 -> out_valid=0, out_data=0, out_src=0 immediately, with no clock edge required. After release, RR mode with in_valid=4'b1111 -> first out_src=0.
- Fixed mode: sel=2, in_valid=4'b1111, in_data ch2=64'h0000_0000_DEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=64'hDEADBEEF, out_src=2. Also sel=2 with in_valid[2]=0 -> out_valid=0 next cycle.
- RR fairness:
  - in_valid=4'b1111, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3.
  - in_valid=4'b1010 -> sequence 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_src stable and in_ready=4'b0000. On out_ready=1 -> back-to-back transfers with no bubble.
- Mode switch: in RR mode after granting ch1, switch to fixed mode with sel=3 for 2 transfers, then back to RR -> next RR grant is ch2, proving rr_ptr was held.
- MUX_ARB_GRANT_CNT_EN: 5 transfers from ch0 -> grant_cnt ch0=5, others 0. Force 65540 ch0 grants -> ch0 counter holds 16'hFFFF.
